// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one imem read at a time over a
// valid/ready channel, captures the variable-latency response into a
// single-entry buffer for decode, and applies redirects with priority,
// killing any fetch still in flight from the old path.
module fetch_ctrl #(
  parameter int unsigned   N        = 64,
  parameter int unsigned   IW       = 32,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect_valid,
  input  logic [N-1:0]  redirect_pc,
  input  logic          stall_D,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [N-1:0]  imem_req_addr,
  input  logic          imem_resp_valid,
  input  logic [IW-1:0] imem_resp_data,
  output logic          instr_valid_D,
  output logic [IW-1:0] instr_D,
  output logic [N-1:0]  pc_D
);

  typedef enum logic {
    S_REQ,
    S_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  pc_q, pc_d;
  logic [N-1:0]  infl_pc_q, infl_pc_d;
  logic          kill_q, kill_d;
  logic          bvalid_q, bvalid_d;
  logic [IW-1:0] binstr_q, binstr_d;
  logic [N-1:0]  bpc_q, bpc_d;

  logic          consume;
  logic          handshake;
  logic          resp;
  logic          fill;
  logic [N-1:0]  redirect_tgt;

  // Decode drains the buffer whenever it holds something and is not stalled.
  // A request may issue when the buffer is empty or being drained this cycle,
  // so the buffer is always free by the time the single response returns.
  assign consume        = bvalid_q & ~stall_D;
  assign imem_req_valid = reset & (state_q == S_REQ) & (~bvalid_q | consume);
  assign imem_req_addr  = pc_q;
  assign handshake      = imem_req_valid & imem_req_ready;
  assign resp           = (state_q == S_WAIT) & imem_resp_valid;
  assign fill           = resp & ~kill_q & ~redirect_valid;
  assign redirect_tgt   = {redirect_pc[N-1:2], 2'b00};

  assign instr_valid_D  = bvalid_q;
  assign instr_D        = binstr_q;
  assign pc_D           = bpc_q;

  // Next-state logic: normal sequencing first, then redirect overrides.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    infl_pc_d = infl_pc_q;
    kill_d    = kill_q;
    bvalid_d  = bvalid_q;
    binstr_d  = binstr_q;
    bpc_d     = bpc_q;

    unique case (state_q)
      S_REQ: begin
        if (handshake) begin
          infl_pc_d = pc_q;
          pc_d      = pc_q + N'(4);
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp) begin
          state_d = S_REQ;
          if (kill_q) kill_d = 1'b0;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (fill) begin
      bvalid_d = 1'b1;
      binstr_d = imem_resp_data;
      bpc_d    = infl_pc_q;
    end else if (consume) begin
      bvalid_d = 1'b0;
    end

    // Redirect wins over everything above in the same cycle.
    if (redirect_valid) begin
      pc_d     = redirect_tgt;
      bvalid_d = 1'b0;
      if (state_q == S_WAIT) begin
        // A response arriving now is the one being dropped; otherwise mark
        // the outstanding fetch so its response is dropped later.
        kill_d = ~resp;
      end else if (handshake) begin
        // The request just accepted belongs to the old path.
        state_d = S_WAIT;
        kill_d  = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      infl_pc_q <= '0;
      kill_q    <= 1'b0;
      bvalid_q  <= 1'b0;
      binstr_q  <= '0;
      bpc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_pc_q <= infl_pc_d;
      kill_q    <= kill_d;
      bvalid_q  <= bvalid_d;
      binstr_q  <= binstr_d;
      bpc_q     <= bpc_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl. A small imem responder answers each
// accepted request after mem_lat cycles with {16'hBEEF, addr[15:0]}.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 units after the edge, requests are observed on the falling edge.
module tb_fetch_ctrl;

  localparam int unsigned N  = 64;
  localparam int unsigned IW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          redirect_valid;
  logic [N-1:0]  redirect_pc;
  logic          stall_D;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [N-1:0]  imem_req_addr;
  logic          imem_resp_valid;
  logic [IW-1:0] imem_resp_data;
  logic          instr_valid_D;
  logic [IW-1:0] instr_D;
  logic [N-1:0]  pc_D;

  int tests_run    = 0;
  int tests_failed = 0;

  int           mem_lat  = 1;
  int           pend_cnt = 0;
  logic [N-1:0] pend_addr = '0;
  logic [N-1:0] hs_q[$];

  fetch_ctrl #(.N(N), .IW(IW), .RESET_PC(64'h1000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_D        (stall_D),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid_D  (instr_valid_D),
    .instr_D        (instr_D),
    .pc_D           (pc_D)
  );

  always #5 clk = ~clk;

  // One clock cycle: log a handshake seen before the edge, then advance the
  // imem responder just after the edge.
  task automatic tick();
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      hs_q.push_back(imem_req_addr);
      pend_cnt  = mem_lat;
      pend_addr = imem_req_addr;
    end
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = {16'hBEEF, pend_addr[15:0]};
      end
    end
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    stall_D         = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    mem_lat         = 1;
    pend_cnt        = 0;
    hs_q.delete();
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    stall_D         = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    #2;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
      tests_run++;
      if (instr_valid_D !== 1'b0) begin tests_failed++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid_D); end
      tick();
    end
    tests_run++;
    if (instr_D !== 32'h0 || pc_D !== 64'h0) begin tests_failed++; $display("FAIL reset_buffer: got instr %h pc %h expected 0 0", instr_D, pc_D); end
    tests_run++;
    if (imem_req_addr !== 64'h1000) begin tests_failed++; $display("FAIL reset_addr: got %h expected 1000", imem_req_addr); end
  endtask

  task automatic test_sequential();
    logic [N-1:0]  exp_pc[3];
    logic [IW-1:0] exp_in[3];
    exp_pc = '{64'h1000, 64'h1004, 64'h1008};
    exp_in = '{32'hBEEF1000, 32'hBEEF1004, 32'hBEEF1008};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      while (instr_valid_D !== 1'b1 && n < 8) begin tick(); n++; end
      tests_run++;
      if (instr_valid_D !== 1'b1) begin tests_failed++; $display("FAIL seq_valid_timeout[%0d]: got %b expected 1", k, instr_valid_D); end
      tests_run++;
      if (pc_D !== exp_pc[k] || instr_D !== exp_in[k]) begin
        tests_failed++; $display("FAIL seq_data[%0d]: got pc %h instr %h expected pc %h instr %h", k, pc_D, instr_D, exp_pc[k], exp_in[k]);
      end
      tick();
    end
    tests_run++;
    if (hs_q.size() < 3) begin
      tests_failed++; $display("FAIL seq_req_count: got %0d expected >=3", hs_q.size());
    end else if (hs_q[0] !== exp_pc[0] || hs_q[1] !== exp_pc[1] || hs_q[2] !== exp_pc[2]) begin
      tests_failed++; $display("FAIL seq_req_order: got %h %h %h expected 1000 1004 1008", hs_q[0], hs_q[1], hs_q[2]);
    end
  endtask

  task automatic test_not_ready();
    do_reset();
    imem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000) begin
        tests_failed++; $display("FAIL hold_req[%0d]: got valid %b addr %h expected 1 1000", i, imem_req_valid, imem_req_addr);
      end
      tick();
    end
    tests_run++;
    if (hs_q.size() != 0) begin tests_failed++; $display("FAIL hold_no_hs: got %0d expected 0", hs_q.size()); end
    imem_req_ready = 1'b1;
    tick();
    #1;
    tests_run++;
    if (hs_q.size() != 1 || imem_req_valid !== 1'b0) begin
      tests_failed++; $display("FAIL hold_one_req: got count %0d valid %b expected 1 0", hs_q.size(), imem_req_valid);
    end
    tick();
    #1;
    tests_run++;
    if (instr_valid_D !== 1'b1 || pc_D !== 64'h1000) begin
      tests_failed++; $display("FAIL hold_fill: got valid %b pc %h expected 1 1000", instr_valid_D, pc_D);
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    stall_D = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (instr_valid_D !== 1'b1 || instr_D !== 32'hBEEF1000 || pc_D !== 64'h1000 || imem_req_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got v %b instr %h pc %h req %b expected 1 beef1000 1000 0", i, instr_valid_D, instr_D, pc_D, imem_req_valid);
      end
      tick();
    end
    stall_D = 1'b0;
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1004) begin
      tests_failed++; $display("FAIL stall_release_req: got valid %b addr %h expected 1 1004", imem_req_valid, imem_req_addr);
    end
    tick();
    #1;
    tests_run++;
    if (hs_q.size() != 2 || instr_valid_D !== 1'b0) begin
      tests_failed++; $display("FAIL stall_after: got count %0d valid %b expected 2 0", hs_q.size(), instr_valid_D);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_lat = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2002;
    tick();
    redirect_valid = 1'b0;
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'h2000) begin
      tests_failed++; $display("FAIL rdw_wait: got valid %b addr %h expected 0 2000", imem_req_valid, imem_req_addr);
    end
    tick();
    tests_run++;
    if (imem_resp_valid !== 1'b1 || instr_valid_D !== 1'b0) begin
      tests_failed++; $display("FAIL rdw_resp_cycle: got resp %b valid %b expected 1 0", imem_resp_valid, instr_valid_D);
    end
    mem_lat = 1;
    tick();
    #1;
    tests_run++;
    if (instr_valid_D !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000) begin
      tests_failed++; $display("FAIL rdw_dropped: got v %b req %b addr %h expected 0 1 2000", instr_valid_D, imem_req_valid, imem_req_addr);
    end
    tick();
    tick();
    #1;
    tests_run++;
    if (instr_valid_D !== 1'b1 || pc_D !== 64'h2000 || instr_D !== 32'hBEEF2000) begin
      tests_failed++; $display("FAIL rdw_new_path: got v %b pc %h instr %h expected 1 2000 beef2000", instr_valid_D, pc_D, instr_D);
    end
  endtask

  task automatic test_redirect_handshake();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1008) begin
      tests_failed++; $display("FAIL rdh_setup: got valid %b addr %h expected 1 1008", imem_req_valid, imem_req_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    #1;
    tests_run++;
    if (instr_valid_D !== 1'b0 || imem_req_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rdh_killed_resp: got v %b req %b expected 0 0", instr_valid_D, imem_req_valid);
    end
    tick();
    #1;
    tests_run++;
    if (instr_valid_D !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h3000) begin
      tests_failed++; $display("FAIL rdh_next_req: got v %b req %b addr %h expected 0 1 3000", instr_valid_D, imem_req_valid, imem_req_addr);
    end
    tick();
    tick();
    #1;
    tests_run++;
    if (instr_valid_D !== 1'b1 || pc_D !== 64'h3000 || instr_D !== 32'hBEEF3000) begin
      tests_failed++; $display("FAIL rdh_new_path: got v %b pc %h instr %h expected 1 3000 beef3000", instr_valid_D, pc_D, instr_D);
    end
    tests_run++;
    if (hs_q.size() != 4 || hs_q[2] !== 64'h1008 || hs_q[3] !== 64'h3000) begin
      tests_failed++; $display("FAIL rdh_req_log: got count %0d expected 4 ending 1008 3000", hs_q.size());
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    mem_lat = 3;
    tick();
    reset    = 1'b0;
    pend_cnt = 0;
    hs_q.delete();
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b0 || instr_valid_D !== 1'b0 || imem_req_addr !== 64'h1000) begin
      tests_failed++; $display("FAIL rmf_in_reset: got req %b v %b addr %h expected 0 0 1000", imem_req_valid, instr_valid_D, imem_req_addr);
    end
    tick();
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEADBEEF;
    #1;
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000) begin
      tests_failed++; $display("FAIL rmf_first_req: got valid %b addr %h expected 1 1000", imem_req_valid, imem_req_addr);
    end
    tick();
    tests_run++;
    if (instr_valid_D !== 1'b0) begin tests_failed++; $display("FAIL rmf_stale_ignored: got %b expected 0", instr_valid_D); end
    imem_req_ready = 1'b1;
    mem_lat        = 1;
    tick();
    tests_run++;
    if (instr_valid_D !== 1'b0) begin tests_failed++; $display("FAIL rmf_before_resp: got %b expected 0", instr_valid_D); end
    tick();
    #1;
    tests_run++;
    if (instr_valid_D !== 1'b1 || pc_D !== 64'h1000 || instr_D !== 32'hBEEF1000) begin
      tests_failed++; $display("FAIL rmf_real_resp: got v %b pc %h instr %h expected 1 1000 beef1000", instr_valid_D, pc_D, instr_D);
    end
    tests_run++;
    if (hs_q.size() < 1 || hs_q[0] !== 64'h1000) begin
      tests_failed++; $display("FAIL rmf_req_addr: got count %0d expected first request 1000", hs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_not_ready();
    test_stall();
    test_redirect_wait();
    test_redirect_handshake();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences the fetch stage. It owns the PC register, issues one instruction-memory read at a time over a valid/ready request channel, and accepts a variable-latency response. The fetched word is held in a single-entry output buffer for decode. Branch/exception redirects are applied with priority, and any in-flight fetch from the old path is killed.

Parameters:
N, 64, PC / address width
IW, 32, instruction width
RESET_PC, 0, PC value loaded on reset (low 2 bits must be 0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
redirect_valid  in  1  redirect request from a later stage
redirect_pc  in  N  redirect target; bits [1:0] ignored (treated as 0)
stall_D  in  1  decode cannot accept an instruction this cycle
imem_req_valid  out  1  request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_req_addr  out  N  request address = current PC register
imem_resp_valid  in  1  response valid; never in the same cycle as its request's acceptance
imem_resp_data  in  IW  response instruction word
instr_valid_D  out  1  output buffer holds a valid instruction
instr_D  out  IW  buffered instruction
pc_D  out  N  address of buffered instruction

Behaviour:
- State: pc (N), infl_pc (N), kill (1), FSM {REQ, WAIT}, buffer {bvalid, binstr, bpc}.
- Reset (reset==0, async): pc=RESET_PC, FSM=REQ, kill=0, bvalid=0, binstr=0, bpc=0. All outputs read 0 while in reset: imem_req_valid, instr_valid_D, instr_D, pc_D. imem_req_addr = pc.
- Reset mid-fetch abandons the outstanding request. Any later response is never accepted, because FSM=REQ ignores imem_resp_valid.
- consume = bvalid & ~stall_D. instr_valid_D=bvalid, instr_D=binstr, pc_D=bpc.
- REQ state:
  - imem_req_valid = ~bvalid | consume. At most one request is outstanding, and the buffer is guaranteed free when the response arrives.
  - imem samples imem_req_addr only at handshake (valid & ready). The address may change while valid & ~ready, for example on a redirect.
  - On handshake: infl_pc<=pc, pc<=pc+4 (mod 2^N, wraps silently), FSM->WAIT.
  - imem_resp_valid is ignored in REQ.
- WAIT state:
  - imem_req_valid=0.
  - On imem_resp_valid with kill==0: bvalid<=1, binstr<=imem_resp_data, bpc<=infl_pc, FSM->REQ.
  - On imem_resp_valid with kill==1: data dropped, kill<=0, buffer untouched, FSM->REQ.
- Buffer: when consume occurs with no new fill the same cycle, bvalid<=0.
- Redirect (redirect_valid==1) has priority over every other update in the same cycle:
  - pc <= {redirect_pc[N-1:2],2'b00}; bvalid<=0, even if consume is high that cycle.
  - In WAIT with no response this cycle: kill<=1.
  - In WAIT with a response this cycle: response dropped, kill<=0, FSM->REQ.
  - In REQ with a handshake this cycle: the accepted request is killed (FSM->WAIT, kill<=1), infl_pc is irrelevant, and pc <= target, not pc+4.
  - In REQ without a handshake: FSM stays REQ, and the next request uses the target.
  - Back-to-back redirects: the last one wins. The kill flag stays 1 until exactly one response is dropped.
- Latency: with no stall and 1-cycle imem, the request at cycle t is answered at t+1 and is visible to decode at t+2. The next request issues at t+2, which is the same cycle the buffer is consumed. Throughput is one instruction per 2 cycles with 1-cycle memory.
- No combinational path from imem_resp_* to any output. imem_req_valid depends combinationally on stall_D.

Test Plan:
1. Reset release, RESET_PC=0x1000, ready=1, 1-cycle resp, stall_D=0 -> addresses 0x1000, 0x1004, 0x1008 in order. pc_D/instr_D match each. instr_valid_D is never high during reset.
2. Hold imem_req_ready=0 for 3 cycles -> imem_req_valid stays 1 with addr 0x1000. No PC increment. On ready=1, exactly one request.
3. stall_D=1 for 4 cycles with buffer full -> instr_valid_D, instr_D, pc_D stable and imem_req_valid=0. The request issues in the first cycle stall_D=0.
4. Redirect to 0x2002 while in WAIT, response 3 cycles later -> response dropped with instr_valid_D staying 0. Next request addr=0x2000, next pc_D=0x2000.
5. Redirect to 0x3000 in the same cycle as a request handshake at 0x1008 -> that response is dropped. The next request is 0x3000, not 0x100C.
6. Assert reset low while in WAIT, release, then pulse a stale imem_resp_valid -> stale response ignored. First request is at RESET_PC, and instr_valid_D=0 until the real response.
